// File: rtl/stream_mux_rr_pkg.sv
// Shared types and width helpers for the N:1 stream multiplexer.
// Imported by the interface, the round-robin picker and the top level.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Width of a channel index; never below 1 so a 2-channel mux still has a select bit.
  function automatic int sel_len(input int nr_ch);
    return (nr_ch <= 2) ? 1 : $clog2(nr_ch);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundle of the producer-side and consumer-side stream signals of stream_mux_rr.
// Handshake: a beat moves when valid && ready on the same rising edge; valid may drop without a transfer.
interface stream_mux_rr_if #(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 2
);
  import stream_mux_pkg::*;

  localparam int SEL_LEN = sel_len(NR_CH);

  mux_mode_e                    mode;
  logic [SEL_LEN-1:0]           sel;
  logic [NR_CH-1:0]             in_valid;
  logic [NR_CH*DATA_LEN-1:0]    in_data;
  logic [NR_CH-1:0]             in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_LEN-1:0]          out_data;
  logic [SEL_LEN-1:0]           out_ch;

  // Environment side: producers, consumer and arbitration control.
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  // Multiplexer side.
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/stream_mux_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Requests are doubled so bits below ptr reappear in the upper half after masking.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter  int NR_CH   = 4,
  localparam int SEL_LEN = sel_len(NR_CH)
) (
  input  logic [NR_CH-1:0]   req,
  input  logic [SEL_LEN-1:0] ptr,
  output logic [NR_CH-1:0]   gnt,
  output logic [SEL_LEN-1:0] gnt_idx,
  output logic               gnt_vld
);

  logic [2*NR_CH-1:0] req_dbl;
  logic [2*NR_CH-1:0] masked;
  int                 pos;

  assign req_dbl = {req, req};

  always_comb begin
    masked  = '0;
    pos     = 0;
    gnt_vld = 1'b0;
    for (int j = 0; j < 2*NR_CH; j++) begin
      masked[j] = req_dbl[j] && (j >= int'(ptr));
    end
    for (int j = 0; j < 2*NR_CH; j++) begin
      if (!gnt_vld && masked[j]) begin
        gnt_vld = 1'b1;
        pos     = (j >= NR_CH) ? (j - NR_CH) : j;
      end
    end
    gnt_idx = SEL_LEN'(pos);
    gnt     = '0;
    for (int i = 0; i < NR_CH; i++) begin
      gnt[i] = gnt_vld && (pos == i);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream multiplexer with fixed-select or round-robin arbitration and a
// registered output stage sustaining one beat per cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NR_CH    = 4,
  parameter  int DATA_LEN = 2,
  localparam int SEL_LEN  = sel_len(NR_CH)
) (
  input logic           clk,
  input logic           rst,
  stream_mux_rr_if.slave bus
);

  logic                 accept;
  logic [NR_CH-1:0]     fixed_gnt;
  logic                 fixed_vld;
  logic [NR_CH-1:0]     rr_gnt;
  logic [SEL_LEN-1:0]   rr_idx;
  logic                 rr_vld;
  logic [NR_CH-1:0]     grant;
  logic [SEL_LEN-1:0]   grant_idx;
  logic                 grant_vld;
  logic [DATA_LEN-1:0]  grant_data;
  logic [SEL_LEN-1:0]   rr_ptr;
  logic [SEL_LEN-1:0]   rr_next;

  logic                 out_valid_q;
  logic [DATA_LEN-1:0]  out_data_q;
  logic [SEL_LEN-1:0]   out_ch_q;

  // The output slot is free when empty or being drained this cycle.
  assign accept = !out_valid_q || bus.out_ready;

  // A select value beyond the last channel simply matches nothing.
  always_comb begin
    fixed_gnt = '0;
    for (int i = 0; i < NR_CH; i++) begin
      fixed_gnt[i] = bus.in_valid[i] && (bus.sel == SEL_LEN'(i));
    end
  end
  assign fixed_vld = |fixed_gnt;

  rr_pick #(.NR_CH(NR_CH)) u_pick (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    if (bus.mode == MODE_RR) begin
      grant     = rr_gnt;
      grant_idx = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant     = fixed_gnt;
      grant_idx = bus.sel;
      grant_vld = fixed_vld;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NR_CH; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*DATA_LEN +: DATA_LEN];
    end
  end

  assign rr_next = (grant_idx == SEL_LEN'(NR_CH - 1)) ? '0 : grant_idx + 1'b1;

  assign bus.in_ready = (rst || !accept) ? '0 : grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      if (grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_ch_q    <= grant_idx;
        if (bus.mode == MODE_RR) rr_ptr <= rr_next;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (NR_CH=4, DATA_LEN=2) with hand-computed expectations.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  stream_mux_rr_if #(.NR_CH(4), .DATA_LEN(2)) bus ();

  stream_mux_rr #(.NR_CH(4), .DATA_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ch3..ch0 = 3,2,1,0
  localparam logic [7:0] DATA_IDX = {2'd3, 2'd2, 2'd1, 2'd0};

  task automatic apply_reset();
    rst          = 1'b1;
    bus.mode     = MODE_RR;
    bus.sel      = '0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst          = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data  = DATA_IDX;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
    end
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_ch} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs: got v=%b d=%0d ch=%0d want 0/0/0",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = '0;
  endtask

  task automatic test_rr_rotation();
    logic [1:0] exp_ch;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.mode     = MODE_RR;
      bus.in_valid = 4'b1111;
      bus.in_data  = DATA_IDX;
      bus.out_ready = 1'b1;
      exp_ch = 2'(k % 4);
      #1;
      n_cmp++;
      if (bus.in_ready !== (4'b0001 << exp_ch)) begin
        n_err++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, bus.in_ready, 4'b0001 << exp_ch);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch || bus.out_data !== exp_ch) begin
        n_err++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%0d want 1/%0d/%0d",
                          k, bus.out_valid, bus.out_ch, bus.out_data, exp_ch, exp_ch);
      end
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mode     = MODE_FIXED;
      bus.sel      = 2'd2;
      bus.in_valid = 4'b1111;
      bus.in_data  = DATA_IDX;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0100) begin
        n_err++; $display("FAIL fixed_in_ready[%0d]: got %b want 0100", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_data !== 2'b10) begin
        n_err++; $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%0d want 1/2/2",
                          k, bus.out_valid, bus.out_ch, bus.out_data);
      end
    end
    // Pointer untouched by fixed transfers: round-robin must start at ch0.
    @(negedge clk);
    bus.mode = MODE_RR;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_err++; $display("FAIL fixed_ptr_kept: got %b want 0001", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_ch !== 2'd0) begin
      n_err++; $display("FAIL fixed_ptr_out: got ch=%0d want 0", bus.out_ch);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    bus.mode      = MODE_RR;
    bus.in_valid  = 4'b0110;
    bus.in_data   = DATA_IDX;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 2'd1) begin
      n_err++; $display("FAIL bp_first: got v=%b ch=%0d d=%0d want 1/1/1",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      // Mode flip while stalled must not disturb the held beat.
      bus.mode = (k == 1) ? MODE_FIXED : MODE_RR;
      bus.sel  = 2'd2;
      #1;
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 2'd1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0d want 1/1/1",
                          k, bus.out_valid, bus.out_ch, bus.out_data);
      end
    end
    @(negedge clk);
    bus.mode      = MODE_RR;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 0100", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_data !== 2'd2) begin
      n_err++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%0d want 1/2/2",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b0100;
    bus.in_data  = DATA_IDX;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_ch !== 2'd2) begin
      n_err++; $display("FAIL wrap_ch2: got ch=%0d want 2", bus.out_ch);
    end
    @(negedge clk);
    bus.in_valid = 4'b0001;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_err++; $display("FAIL wrap_ready: got %b want 0001", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 2'd0) begin
      n_err++; $display("FAIL wrap_out: got v=%b ch=%0d d=%0d want 1/0/0",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
    // Pointer now 1: with ch0 and ch1 requesting, ch1 wins.
    @(negedge clk);
    bus.in_valid = 4'b0011;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0010) begin
      n_err++; $display("FAIL wrap_ptr1: got %b want 0010", bus.in_ready);
    end
    @(posedge clk);
  endtask

  task automatic test_sparse();
    apply_reset();
    @(negedge clk);
    bus.mode     = MODE_RR;
    bus.in_valid = 4'b1000;
    bus.in_data  = DATA_IDX;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== 2'd3) begin
      n_err++; $display("FAIL sparse_first: got v=%b ch=%0d d=%0d want 1/3/3",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.in_valid = 4'b0000;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_ch !== 2'd3 || bus.out_data !== 2'd3) begin
        n_err++; $display("FAIL sparse_idle[%0d]: got v=%b ch=%0d d=%0d want 0/3/3",
                          k, bus.out_valid, bus.out_ch, bus.out_data);
      end
    end
    @(negedge clk);
    bus.in_valid = 4'b1000;
    bus.in_data  = {2'd1, 2'd2, 2'd3, 2'd0};
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b1000) begin
      n_err++; $display("FAIL sparse_ready: got %b want 1000", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== 2'd1) begin
      n_err++; $display("FAIL sparse_resume: got v=%b ch=%0d d=%0d want 1/3/1",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.mode     = MODE_RR;
      bus.in_valid = 4'b1111;
      bus.in_data  = DATA_IDX;
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 2'd1) begin
      n_err++; $display("FAIL areset_pre: got v=%b ch=%0d d=%0d want 1/1/1",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_ch} !== 5'b0 || bus.in_ready !== 4'b0000) begin
      n_err++; $display("FAIL areset_now: got v=%b d=%0d ch=%0d rdy=%b want 0/0/0/0000",
                        bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 4'b0001) begin
      n_err++; $display("FAIL areset_restart_ready: got %b want 0001", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 2'd0) begin
      n_err++; $display("FAIL areset_restart_out: got v=%b ch=%0d d=%0d want 1/0/0",
                        bus.out_valid, bus.out_ch, bus.out_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_rr_rotation();
    test_fixed();
    test_backpressure();
    test_wrap();
    test_sparse();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer. It is the successor to the team's fixed 4:1 combinational mux.
- Adds valid/ready handshaking per channel and a registered output stage.
- Offers a runtime choice of fixed-select or round-robin arbitration.
- Sits between multiple producer streams and a single consumer, e.g. merging channel results onto one bus.

Parameters:
- NR_CH, 4: number of input channels, >= 2.
- DATA_LEN, 2: payload width per channel, >= 1.
- SEL_LEN, $clog2(NR_CH): width of sel and out_ch. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = FIXED (channel sel only), 1 = RR (round-robin over all channels).
- sel  input  SEL_LEN  channel index used in FIXED mode; ignored in RR mode.
- in_valid  input  NR_CH  per-channel valid.
- in_data  input  NR_CH*DATA_LEN  packed payloads; channel i at [i*DATA_LEN +: DATA_LEN].
- in_ready  output  NR_CH  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  DATA_LEN  registered payload.
- out_ch  output  SEL_LEN  index of the channel that produced out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr_ptr=0 (channel 0 highest priority). While rst=1, in_ready=0.
- Slot-free condition: accept = !out_valid || out_ready. Combinational from out_ready, so full throughput of 1 beat/cycle is supported.
- Grant (combinational, only when accept=1):
  - FIXED mode: grant channel sel if in_valid[sel]=1. If sel >= NR_CH (non-power-of-two NR_CH), there is no grant.
  - RR mode: grant the first valid channel scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NR_CH.
- in_ready[i] = accept && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Clock edge with grant: out_data <= in_data[g], out_ch <= g, out_valid <= 1. Latency: input transfer to out_valid = 1 cycle.
- Clock edge with accept=1 and no grant: out_valid <= 0. out_data/out_ch hold their last values.
- Clock edge with accept=0 (out_valid=1, out_ready=0): all output registers hold; in_ready=0 to every channel.
- rr_ptr update:
  - Only on a granted transfer in RR mode: rr_ptr <= (g+1) mod NR_CH, wrapping from NR_CH-1 to 0.
  - FIXED-mode transfers leave rr_ptr unchanged.
- Mode/sel changes take effect at the next arbitration. They never alter a beat already held in the output register.
- in_valid deasserting without a transfer is tolerated; no protocol checking.
- Reset mid-transfer: the held beat is discarded, out_valid drops immediately (asynchronous), and rr_ptr returns to 0.
- Combinational paths: out_ready -> in_ready, in_valid -> in_ready, mode/sel -> in_ready. There is no combinational path from inputs to out_*.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e.
  - Helper constant/function for SEL_LEN.
- Sub-module rr_pick (parameter NR_CH): combinational.
  - Inputs: req[NR_CH], ptr[SEL_LEN].
  - Outputs: gnt one-hot, gnt_idx, gnt_vld.
  - Implemented as a double-width masked priority encoder.
- Top level holds accept logic, the FIXED/RR select, rr_ptr and the output register.

Test Plan:
1. Reset, then RR mode, all four in_valid=1, in_data={3,2,1,0} (ch3..ch0), out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid=1 from the cycle after the first grant.
2. FIXED mode, sel=2, in_valid=4'b1111, in_data[2]=2'b10 -> only in_ready[2] asserts; out_data=2'b10, out_ch=2 every cycle; rr_ptr stays 0.
3. Backpressure: RR mode, in_valid=4'b0110, out_ready=0 after the first beat -> out_data/out_ch hold (ch1) and in_ready=0. Release out_ready -> next beat is from ch2.
4. Wrap-around: RR mode, rr_ptr at 3 (after a ch2 grant), in_valid=4'b0001 -> ch0 granted, rr_ptr becomes 1.
5. Sparse/empty: in_valid=0 with out_ready=1 -> out_valid drops the cycle after the last beat and out_data holds its value. Then assert in_valid[3] -> out_valid=1, out_ch=3 one cycle later.
6. Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately. After release, RR restarts from ch0.
